// File: rtl/ysyx_22041412_axi_master_if.sv
// ysyx_22041412_axi_master_if: AXI4 AR/R/AW/W/B bundle between the core-side master bridge and the SoC interconnect
// master modport: drives AR/AW/W valids and payloads plus R/B ready; receives AR/AW/W ready, R/B valid and payloads
// slave modport: the mirror image, used by the interconnect or a bench model
interface ysyx_22041412_axi_master_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                        ar_valid, ar_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        r_valid, r_ready, r_last;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic                        aw_valid, aw_ready;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        w_valid, w_ready, w_last;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        b_valid, b_ready;
  logic [1:0]                  b_resp;
  logic [AXI_ID_WIDTH-1:0]     b_id;
  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id,
    output r_ready,
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp, b_id,
    output b_ready
  );
  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id,
    input  r_ready,
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp, b_id,
    input  b_ready
  );
endinterface

// File: rtl/ysyx_22041412_axi_master.sv
// ysyx_22041412_axi_master: arbiter request/beat interface to AXI4 master, independent read and write FSMs
// clk/rst: clock, synchronous active-high reset
// r_*: read request (valid held until r_last_i), r_ready_o/data_read_o/r_last_i per delivered beat
// w_*: write request (valid held until w_last_i), w_ready_o per accepted beat, w_last_i on B response
// axi_err_o: sticky bad-response flag, only live when AXI_RESP_CHECK_EN is defined, else tied 0
// axi: AXI4 master modport (AR/R/AW/W/B)
module ysyx_22041412_axi_master #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      r_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] r_addr_i,
  input  logic [2:0]                r_size_i,
  input  logic [7:0]                r_len_i,
  output logic                      r_ready_o,
  output logic [AXI_DATA_WIDTH-1:0] data_read_o,
  output logic                      r_last_i,
  input  logic                      w_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] w_addr_i,
  input  logic [2:0]                w_size_i,
  input  logic [7:0]                w_len_i,
  input  logic [AXI_DATA_WIDTH-1:0] rw_w_data_i,
  output logic                      w_ready_o,
  output logic                      w_last_i,
  output logic                      axi_err_o,
  ysyx_22041412_axi_master_if.master axi
);
  localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
  logic [1:0]                rs, ws;
  logic                      r_cancel;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, aw_addr_q;
  logic [7:0]                ar_len_q, aw_len_q, w_cnt;
  logic [2:0]                ar_size_q, aw_size_q;
  logic                      r_hs, w_hs, b_hs, r_deliver;
  logic [1:0]                sz;
  logic [3:0]                bytes;
  logic [15:0]               strb_full;
  logic                      unused_ok;
  assign r_hs      = axi.r_valid & axi.r_ready;
  assign w_hs      = axi.w_valid & axi.w_ready;
  assign b_hs      = axi.b_valid & axi.b_ready;
  assign r_deliver = r_hs & r_valid_i & ~r_cancel;
  assign sz        = aw_size_q[2] ? 2'd3 : aw_size_q[1:0];
  assign bytes     = 4'd1 << sz;
  assign strb_full = ((16'd1 << bytes) - 16'd1) << aw_addr_q[2:0];
  assign axi.ar_valid = rs == R_AR;
  assign axi.ar_addr  = ar_addr_q;
  assign axi.ar_id    = '0;
  assign axi.ar_len   = ar_len_q;
  assign axi.ar_size  = ar_size_q;
  assign axi.ar_burst = 2'b01;
  assign axi.r_ready  = rs == R_DATA;
  assign axi.aw_valid = ws == W_AW;
  assign axi.aw_addr  = aw_addr_q;
  assign axi.aw_id    = '0;
  assign axi.aw_len   = aw_len_q;
  assign axi.aw_size  = aw_size_q;
  assign axi.aw_burst = 2'b01;
  assign axi.w_valid  = ws == W_DATA;
  assign axi.w_data   = rw_w_data_i;
  assign axi.w_strb   = strb_full[7:0];
  assign axi.w_last   = w_cnt == aw_len_q;
  assign axi.b_ready  = ws == W_RESP;
  assign w_ready_o    = w_hs;
  assign unused_ok    = ^{axi.r_id, axi.b_id, axi.r_resp, axi.b_resp, strb_full[15:8]};
  always_ff @(posedge clk) begin
    if (rst) begin
      rs          <= R_IDLE;
      r_cancel    <= 1'b0;
      r_ready_o   <= 1'b0;
      r_last_i    <= 1'b0;
      data_read_o <= '0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
    end else begin
      r_ready_o <= r_deliver;
      r_last_i  <= r_deliver & axi.r_last;
      r_cancel  <= rs != R_IDLE & (r_cancel | ~r_valid_i);
      if (r_hs) data_read_o <= axi.r_data;
      case (rs)
        R_IDLE: if (r_valid_i) begin
          rs        <= R_AR;
          ar_addr_q <= r_addr_i;
          ar_len_q  <= r_len_i;
          ar_size_q <= r_size_i;
        end
        R_AR:    if (axi.ar_ready) rs <= R_DATA;
        R_DATA:  if (r_hs & axi.r_last) rs <= R_IDLE;
        default: rs <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ws        <= W_IDLE;
      w_cnt     <= '0;
      w_last_i  <= 1'b0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
    end else begin
      w_last_i <= b_hs;
      case (ws)
        W_IDLE: if (w_valid_i) begin
          ws        <= W_AW;
          aw_addr_q <= w_addr_i;
          aw_len_q  <= w_len_i;
          aw_size_q <= w_size_i;
        end
        W_AW: if (axi.aw_ready) begin
          ws    <= W_DATA;
          w_cnt <= '0;
        end
        W_DATA: if (w_hs) begin
          w_cnt <= w_cnt + 8'd1;
          ws    <= axi.w_last ? W_RESP : W_DATA;
        end
        W_RESP:  if (b_hs) ws <= W_IDLE;
        default: ws <= W_IDLE;
      endcase
    end
  end
`ifdef AXI_RESP_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((r_hs & |axi.r_resp) | (b_hs & |axi.b_resp)) err_q <= 1'b1;
  end
  assign axi_err_o = err_q;
`else
  assign axi_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_22041412_axi_master.sv
// tb_ysyx_22041412_axi_master: scoreboard bench with AXI slave models and directed read/write requests
module tb_ysyx_22041412_axi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        r_valid_i = 1'b0, w_valid_i = 1'b0;
  logic [31:0] r_addr_i = '0, w_addr_i = '0;
  logic [2:0]  r_size_i = '0, w_size_i = '0;
  logic [7:0]  r_len_i = '0, w_len_i = '0;
  logic [63:0] rw_w_data_i = '0;
  logic        r_ready_o, r_last_i, w_ready_o, w_last_i, axi_err_o;
  logic [63:0] data_read_o;
  ysyx_22041412_axi_master_if axi ();
  ysyx_22041412_axi_master dut (
    .clk(clk), .rst(rst),
    .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_size_i(r_size_i), .r_len_i(r_len_i),
    .r_ready_o(r_ready_o), .data_read_o(data_read_o), .r_last_i(r_last_i),
    .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .w_size_i(w_size_i), .w_len_i(w_len_i),
    .rw_w_data_i(rw_w_data_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .axi_err_o(axi_err_o), .axi(axi.master)
  );
`ifdef AXI_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  typedef struct packed {logic [31:0] a; logic [7:0] l; logic [2:0] s;} addr_t;
  typedef struct packed {logic [63:0] d; logic l;} rd_t;
  typedef struct packed {logic [63:0] d; logic [7:0] s; logic l;} wb_t;
  typedef struct {logic [63:0] d; logic l; int gap;} rbeat_t;
  addr_t  exp_ar[$], exp_aw[$];
  rd_t    exp_rd[$];
  wb_t    exp_w[$];
  rbeat_t rq[$];
  int n_chk = 0, n_fail = 0;
  int w_stall = 0;
  logic [1:0] bresp_cfg = 2'b00;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] beat(input logic [63:0] b, input int i);
    return b + 64'(i) * 64'h0101_0101_0101_0101;
  endfunction
  initial begin
    axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = '0; axi.r_last = 1'b0; axi.r_id = '0;
    @(posedge clk); #1;
    forever begin
      if (rq.size() == 0) begin
        axi.r_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        automatic rbeat_t b = rq.pop_front();
        axi.r_valid = 1'b0;
        repeat (b.gap) begin @(posedge clk); #1; end
        axi.r_valid = 1'b1; axi.r_data = b.d; axi.r_last = b.l;
        do @(negedge clk); while (!axi.r_ready);
        @(posedge clk); #1;
      end
    end
  end
  initial begin
    int wcnt = 0;
    axi.w_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (axi.w_valid && !axi.w_ready) begin
        if (wcnt >= w_stall) begin axi.w_ready = 1'b1; wcnt = 0; end
        else wcnt++;
      end else axi.w_ready = 1'b0;
    end
  end
  initial begin
    axi.b_valid = 1'b0; axi.b_resp = '0; axi.b_id = '0;
    forever begin
      @(negedge clk);
      if (axi.w_valid && axi.w_ready && axi.w_last) begin
        @(posedge clk); #1;
        axi.b_valid = 1'b1; axi.b_resp = bresp_cfg;
        do @(negedge clk); while (!axi.b_ready);
        @(posedge clk); #1;
        axi.b_valid = 1'b0;
      end
    end
  end
  initial begin
    logic prev_rhs = 1'b0, exp_wl = 1'b0, aw_done = 1'b0;
    logic rhs, whs, bhs;
    addr_t a;
    rd_t r;
    wb_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rhs = 1'b0; exp_wl = 1'b0; aw_done = 1'b0;
      end else begin
        rhs = axi.r_valid & axi.r_ready;
        whs = axi.w_valid & axi.w_ready;
        bhs = axi.b_valid & axi.b_ready;
        if (axi.ar_valid && axi.ar_ready) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            a = exp_ar.pop_front();
            chk("ar_addr", axi.ar_addr, a.a);
            chk("ar_len", axi.ar_len, a.l);
            chk("ar_size", axi.ar_size, a.s);
            chk("ar_burst", axi.ar_burst, 2'b01);
          end
        end
        if (axi.aw_valid && axi.aw_ready) begin
          aw_done = 1'b1;
          if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            a = exp_aw.pop_front();
            chk("aw_addr", axi.aw_addr, a.a);
            chk("aw_len", axi.aw_len, a.l);
            chk("aw_size", axi.aw_size, a.s);
            chk("aw_burst", axi.aw_burst, 2'b01);
          end
        end else if (axi.w_valid) chk("w_before_aw", aw_done, 1);
        if (whs || w_ready_o) chk("w_ready_o", w_ready_o, whs);
        if (whs) begin
          if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            w = exp_w.pop_front();
            chk("w_data", axi.w_data, w.d);
            chk("w_strb", axi.w_strb, w.s);
            chk("w_last", axi.w_last, w.l);
          end
          if (axi.w_last) aw_done = 1'b0;
        end
        if (r_ready_o) begin
          chk("r_ready_latency", prev_rhs, 1);
          if (exp_rd.size() == 0) chk("r_ready_unexpected", 1, 0);
          else begin
            r = exp_rd.pop_front();
            chk("data_read_o", data_read_o, r.d);
            chk("r_last_i", r_last_i, r.l);
          end
        end else if (r_last_i) chk("r_last_i_alone", r_last_i, 0);
        prev_rhs = rhs;
        if (w_last_i || exp_wl) chk("w_last_i_timing", w_last_i, exp_wl);
        exp_wl = bhs;
      end
    end
  end
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [63:0] base, input int gap, input int keep);
    int pulses = 0;
    bit done = 0;
    exp_ar.push_back('{addr, len, size});
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{beat(base, i), i == int'(len), gap});
      if (i < keep) exp_rd.push_back('{beat(base, i), i == int'(len)});
    end
    r_addr_i = addr; r_len_i = len; r_size_i = size; r_valid_i = 1'b1;
    @(posedge clk); #1;
    chk("ar_valid_next", axi.ar_valid, 1);
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      if (r_ready_o) pulses++;
      if (keep > int'(len) ? (r_last_i === 1'b1) : (pulses == keep)) begin
        r_valid_i = 1'b0;
        done = 1;
      end
    end
    if (!done) begin r_valid_i = 1'b0; chk("read_timeout", 0, 1); end
  endtask
  task automatic wait_r_idle();
    bit ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (rq.size() == 0 && !axi.r_valid && !axi.r_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    chk("r_drain_idle", ok, 1);
  endtask
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [63:0] base, input int stall, input logic [1:0] bresp,
                          input logic [7:0] strb);
    int idx = 0;
    bit done = 0;
    w_stall = stall; bresp_cfg = bresp;
    exp_aw.push_back('{addr, len, size});
    for (int i = 0; i <= int'(len); i++) exp_w.push_back('{beat(base, i), strb, i == int'(len)});
    w_addr_i = addr; w_len_i = len; w_size_i = size; rw_w_data_i = beat(base, 0); w_valid_i = 1'b1;
    @(posedge clk); #1;
    chk("aw_valid_next", axi.aw_valid, 1);
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (w_ready_o) idx++;
      @(posedge clk); #1;
      rw_w_data_i = beat(base, idx);
      if (w_last_i) begin w_valid_i = 1'b0; done = 1; end
    end
    if (!done) begin w_valid_i = 1'b0; chk("write_timeout", 0, 1); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end
  initial begin
    axi.ar_ready = 1'b1;
    axi.aw_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar_valid", axi.ar_valid, 0);
    chk("rst_aw_valid", axi.aw_valid, 0);
    chk("rst_w_valid", axi.w_valid, 0);
    chk("rst_r_ready", axi.r_ready, 0);
    chk("rst_b_ready", axi.b_ready, 0);
    chk("rst_r_ready_o", r_ready_o, 0);
    chk("rst_r_last_i", r_last_i, 0);
    chk("rst_w_ready_o", w_ready_o, 0);
    chk("rst_w_last_i", w_last_i, 0);
    chk("rst_axi_err_o", axi_err_o, 0);
    chk("rst_data_read_o", data_read_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(32'h8000_0000, 8'd0, 3'd3, 64'h1122_3344_5566_7788, 0, 99);
    do_read(32'h8000_0100, 8'd3, 3'd3, 64'hA000_0000_0000_0010, 2, 99);
    do_read(32'h8000_0200, 8'd3, 3'd3, 64'hC000_0000_0000_0020, 1, 1);
    wait_r_idle();
    do_write(32'h8000_0004, 8'd1, 3'd2, 64'h5000_0000_0000_0001, 3, 2'b00, 8'hF0);
    fork
      do_read(32'h8000_1000, 8'd7, 3'd3, 64'h7000_0000_0000_0000, 0, 99);
      do_write(32'h8000_2000, 8'd0, 3'd3, 64'h3000_0000_0000_0003, 0, 2'b00, 8'hFF);
    join
    do_write(32'h8000_3007, 8'd0, 3'd0, 64'h0000_0000_0000_00AB, 0, 2'b00, 8'h80);
    do_write(32'h8000_3003, 8'd0, 3'd3, 64'h0000_0000_0000_00CD, 1, 2'b00, 8'hF8);
    do_write(32'h8000_3000, 8'd2, 3'd5, 64'h0000_0000_0000_00EF, 0, 2'b00, 8'hFF);
    do_write(32'h8000_3002, 8'd0, 3'd1, 64'h0000_0000_0000_0011, 0, 2'b00, 8'h0C);
    chk("err_clean", axi_err_o, 0);
    do_write(32'h8000_4000, 8'd0, 3'd3, 64'h0000_0000_0000_0022, 0, 2'b10, 8'hFF);
    chk("err_after_bresp", axi_err_o, EXP_ERR);
    do_write(32'h8000_4008, 8'd0, 3'd3, 64'h0000_0000_0000_0033, 0, 2'b00, 8'hFF);
    chk("err_sticky", axi_err_o, EXP_ERR);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("err_cleared_by_rst", axi_err_o, 0);
    rst = 1'b0;
    do_read(32'h8000_5000, 8'd1, 3'd3, 64'h9000_0000_0000_0009, 0, 99);
    repeat (5) @(posedge clk);
    #1;
    chk("exp_rd_empty", exp_rd.size(), 0);
    chk("exp_w_empty", exp_w.size(), 0);
    chk("exp_ar_empty", exp_ar.size(), 0);
    chk("exp_aw_empty", exp_aw.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22041412_axi_master.md
# ysyx_22041412_axi_master

AXI4 master bridge sitting directly downstream of the core's read/write arbiter. It converts the arbiter's simple request/beat interface (held `*_valid_i`, per-beat `*_ready_o` pulse, `*_last_i` completion) into AXI4 AR/R and AW/W/B channel handshakes toward the SoC interconnect. Independent read and write state machines allow one read burst and one write burst in flight concurrently.

## Interface
- `AXI_DATA_WIDTH`, 64, data bus width; must be 64.
- `AXI_ADDR_WIDTH`, 32, address width.
- `AXI_ID_WIDTH`, 4, ID width; all IDs driven 0.
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous, active-high`
- `r_valid_i  in  1`: read request; held until `r_last_i`.
- `r_addr_i  in  ADDR`, `r_size_i  in  3`, `r_len_i  in  8`: read address, beat size, beats−1.
- `r_ready_o  out  1`: one-cycle pulse per delivered read beat.
- `data_read_o  out  DATA`: read beat data, valid with `r_ready_o`.
- `r_last_i  out  1`: high with the final `r_ready_o`.
- `w_valid_i  in  1`: write request; held until `w_last_i`.
- `w_addr_i  in  ADDR`, `w_size_i  in  3`, `w_len_i  in  8`, `rw_w_data_i  in  DATA`: write address, size, beats−1, current beat data (lane-aligned).
- `w_ready_o  out  1`: pulse when the current write beat is accepted; upstream advances data next cycle.
- `w_last_i  out  1`: one-cycle pulse on write completion (B received).
- `axi_err_o  out  1`: sticky error flag (see Configuration).
- `axi_ar_{valid,ready,addr,id,len,size,burst}`: AR channel; valid/addr/id/len/size/burst out, ready in.
- `axi_r_{valid,ready,data,resp,last,id}`: R channel; ready out, rest in.
- `axi_aw_{valid,ready,addr,id,len,size,burst}`: AW channel, directions as AR.
- `axi_w_{valid,ready,data,strb,last}`: W channel; ready in, rest out.
- `axi_b_{valid,ready,resp,id}`: B channel; ready out, rest in.

## Operation
- Burst always INCR (2'b01); IDs 0. AR/AW address, len, size registered at request acceptance.
- Read FSM: R_IDLE → R_AR → R_DATA → R_IDLE.
  - R_IDLE: `r_valid_i`=1 → latch addr/len/size, go R_AR.
  - R_AR: `axi_ar_valid`=1 until `axi_ar_ready`; then R_DATA.
  - R_DATA: `axi_r_ready`=1. Each R handshake registers `rdata` into `data_read_o` and pulses `r_ready_o` next cycle; `axi_r_last` handshake also sets `r_last_i` in that cycle and returns to R_IDLE.
  - Cancel: `r_valid_i` low during R_AR/R_DATA → AR still completes, all remaining R beats drained (`axi_r_ready`=1), `r_ready_o`/`r_last_i` suppressed for the rest of that burst.
- Write FSM: W_IDLE → W_AW → W_DATA → W_RESP → W_IDLE.
  - W_AW: `axi_aw_valid`=1 until `axi_aw_ready`.
  - W_DATA: `axi_w_valid`=1, `axi_w_data`=`rw_w_data_i` (pass-through), 8-bit beat counter from 0; `axi_w_last`=(count==latched len). `w_ready_o`=`axi_w_valid & axi_w_ready` (combinational). Last beat handshake → W_RESP.
  - W_RESP: `axi_b_ready`=1; B handshake → `w_last_i` pulse next cycle, W_IDLE.
- Strobe: `((1<<(1<<size))−1) << addr[2:0]`, truncated to 8 bits; sizes >3 treated as 3. Same strobe every beat.
- Read and write FSMs fully independent; simultaneous requests both proceed; no ordering enforced.

## Timing
- Reset: all AXI valid/ready outputs 0, `r_ready_o`, `r_last_i`, `w_ready_o`, `w_last_i`, `axi_err_o` 0, `data_read_o` 0, both FSMs idle, counters 0.
- Request seen at cycle N → `axi_ar_valid`/`axi_aw_valid` high at N+1.
- R handshake at cycle M → `r_ready_o` + `data_read_o` at M+1.
- B handshake at cycle K → `w_last_i` at K+1; FSM idle at K+1, new request may be accepted at K+1 only if `w_valid_i` still high (upstream deasserts registered at K+2 — upstream must drop valid on the pulse cycle's edge; same rule for reads).
- AXI valids never drop before ready; AW before W strictly (no W before AW handshake).
- Reset mid-burst: FSMs return idle immediately; interconnect is reset together, no drain.

## Configuration
- `AXI_RESP_CHECK_EN` defined: any R or B handshake with `resp`≠2'b00 sets `axi_err_o` (sticky until `rst`); transfer otherwise completes normally.
- Not defined: `resp` ignored, `axi_err_o` tied 0.

## Test plan
- Single read: addr 0x8000_0000, len 0, size 3, slave ready immediately, rdata 0x1122334455667788 → one `r_ready_o` with that data and `r_last_i`=1, `axi_ar_len`=0.
- Burst read len 3 with `axi_r_valid` gaps of 2 cycles → exactly 4 `r_ready_o` pulses, data in order, `r_last_i` only on 4th.
- Read cancel: drop `r_valid_i` after first of 4 beats → `axi_r_ready` stays 1 for all 4, only 1 `r_ready_o`, no `r_last_i`, FSM idle after beat 4.
- Write len 1, size 2, addr 0x8000_0004, `axi_w_ready` stalled 3 cycles → `axi_w_strb`=0xF0, 2 `w_ready_o` pulses, `axi_w_last` on 2nd beat, `w_last_i` one cycle after B.
- Concurrent read len 7 and write len 0 → both complete, no interference, counts correct.
- With `AXI_RESP_CHECK_EN`: bresp=2'b10 → `axi_err_o`=1 and stays until `rst`; without macro stays 0.
